// File: rtl/macc_pkg.sv
// Shared types and constants for the macc matrix port drivers.
package macc_pkg;

  localparam int MACC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOADED,
    DRAIN
  } macc_port_state_e;

endpackage

// File: rtl/macc_matrix_port_driver.sv
// Host-side initiator for one macc matrix port: loads DEPTH words from an
// upstream valid/ready stream via wen, then drains DEPTH words back out via
// ren onto a downstream valid/ready stream.
module macc_matrix_port_driver
  import macc_pkg::*;
#(
  parameter int DATA_W = MACC_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  input  logic              drain_start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              macc_wen,
  output logic [DATA_W-1:0] macc_in,
  output logic              macc_ren,
  input  logic [DATA_W-1:0] macc_out,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  macc_port_state_e  state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              macc_wen_q, macc_wen_d;
  logic [DATA_W-1:0] macc_in_q, macc_in_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              done_q, done_d;
  logic              accept;
  logic              pop;

  // Handshake qualifiers; abort blocks any accept or pop in its own cycle so
  // no wen/ren is issued from that edge on.
  always_comb begin
    s_ready  = (state_q == LOAD) && (wr_cnt_q < DEPTH_C) && !abort;
    accept   = s_ready && s_valid;
    pop      = (state_q == DRAIN) && m_valid_q && m_ready && !abort;
    macc_ren = pop;
  end

  // Next-state, counters and registered port outputs.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    macc_wen_d = accept;
    macc_in_d  = accept ? s_data : macc_in_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_C) state_d = LOADED;
        end
      end
      LOADED: begin
        if (drain_start) begin
          state_d   = DRAIN;
          rd_cnt_d  = '0;
          m_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (pop) begin
          // Drop valid for one cycle so the new macc head can be captured.
          m_valid_d = 1'b0;
          rd_cnt_d  = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_C) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (!m_valid_q && (rd_cnt_q < DEPTH_C)) begin
          // Entry settle cycle and post-pop cycles both land here.
          m_valid_d = 1'b1;
          m_data_d  = macc_out;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      macc_wen_d = 1'b0;
      m_valid_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      macc_wen_q <= 1'b0;
      macc_in_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      macc_wen_q <= macc_wen_d;
      macc_in_q  <= macc_in_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      done_q     <= done_d;
    end
  end

  assign macc_wen = macc_wen_q;
  assign macc_in  = macc_in_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule
